color_select: RTL and testbench

Button-driven colour register stage that feeds the VGA digit renderer. Synchronises and debounces the three colour buttons, detects presses, and loads the corresponding switch fields into the red/green/blue foreground registers that the renderer uses as its digit colour. Everything runs in the 25 MHz pixel-clock domain, so the renderer sees glitch-free registered colour values.

---
 rtl/color_select.sv | 157 +++++++++++++++
 tb/tb_color_select.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/color_select.sv
// color_select: button-driven RGB foreground register stage for the VGA digit renderer.
// Each colour button is synchronised, debounced and edge-detected. A debounced press
// loads that channel's switch field into its colour register.
// Optional feature macro: COLOR_SEL_AUTOREPEAT_EN. When it is defined, a held button
// steps its channel by +1 every REPEAT_CYCLES cycles.
// Channel index used throughout: 0 = red, 1 = green, 2 = blue.
module color_select #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned REPEAT_CYCLES   = 12500000
) (
    input  logic       dclk,
    input  logic       clr,
    input  logic       btnr,
    input  logic       btng,
    input  logic       btnb,
    input  logic [7:0] sw,
    output logic [2:0] red_R,
    output logic [2:0] green_R,
    output logic [1:0] blue_R,
    output logic       upd
);

    localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DbW-1:0] DbMax = DbW'(DEBOUNCE_CYCLES - 1);

    logic [2:0]     btn_raw;
    logic [2:0]     sync1_q, sync2_q;
    logic [2:0]     db_q, db_d, db_prev_q;
    logic [DbW-1:0] cnt_q [3];
    logic [DbW-1:0] cnt_d [3];
    logic [2:0]     press;
    logic [2:0]     tick;

    logic [2:0] red_q, red_d;
    logic [2:0] green_q, green_d;
    logic [1:0] blue_q, blue_d;
    logic       upd_q, upd_d;

    assign btn_raw = {btnb, btng, btnr};

    // Synchronisers, debounced levels, debounce counters and edge-detect registers.
    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            db_prev_q <= db_q;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Debounce: accept a new level only after it has differed for DEBOUNCE_CYCLES cycles.
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == DbMax) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign press = db_q & ~db_prev_q;

`ifdef COLOR_SEL_AUTOREPEAT_EN
    localparam int unsigned RpW = $clog2(REPEAT_CYCLES);
    localparam logic [RpW-1:0] RpMax = RpW'(REPEAT_CYCLES - 1);

    logic [RpW-1:0] rpt_cnt_q [3];
    logic [RpW-1:0] rpt_cnt_d [3];

    // Auto-repeat period counters.
    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < 3; i++) begin
                rpt_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                rpt_cnt_q[i] <= rpt_cnt_d[i];
            end
        end
    end

    // Repeat tick while held. A press in the same cycle wins over the tick.
    always_comb begin
        tick = '0;
        for (int i = 0; i < 3; i++) begin
            tick[i]      = db_q[i] && !press[i] && (rpt_cnt_q[i] == RpMax);
            rpt_cnt_d[i] = (press[i] || !db_q[i] || tick[i]) ? '0 : rpt_cnt_q[i] + 1'b1;
        end
    end
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^REPEAT_CYCLES;
    assign tick = '0;
`endif

    // Colour registers and update pulse.
    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            red_q   <= 3'b111;
            green_q <= 3'b000;
            blue_q  <= 2'b00;
            upd_q   <= 1'b0;
        end else begin
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
            upd_q   <= upd_d;
        end
    end

    // Next colour: a press loads the switch field, a repeat tick increments with wrap.
    always_comb begin
        red_d   = red_q;
        green_d = green_q;
        blue_d  = blue_q;
        if (press[0]) begin
            red_d = sw[2:0];
        end else if (tick[0]) begin
            red_d = red_q + 3'd1;
        end
        if (press[1]) begin
            green_d = sw[5:3];
        end else if (tick[1]) begin
            green_d = green_q + 3'd1;
        end
        if (press[2]) begin
            blue_d = sw[7:6];
        end else if (tick[2]) begin
            blue_d = blue_q + 2'd1;
        end
        // Any write counts, even if the loaded value equals the old one.
        upd_d = |(press | tick);
    end

    assign red_R   = red_q;
    assign green_R = green_q;
    assign blue_R  = blue_q;
    assign upd     = upd_q;

endmodule

// File: tb/tb_color_select.sv
// Bench for color_select using a scoreboard of expected colour updates.
module tb_color_select;

    localparam int unsigned D   = 4;
    localparam int unsigned R   = 8;
    localparam int unsigned Lat = D + 3;  // drive-cycle to upd-observed-cycle distance

    typedef struct {
        int unsigned cyc;
        logic [7:0]  col;
    } exp_t;

    logic       dclk = 1'b0;
    logic       clr;
    logic       btnr, btng, btnb;
    logic [7:0] sw;
    logic [2:0] red_R, green_R;
    logic [1:0] blue_R;
    logic       upd;

    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    bit          mon_en = 1'b0;
    logic [7:0]  mdl_col = 8'hE0;
    exp_t        sb_q[$];

    color_select #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_CYCLES  (R)
    ) dut (
        .dclk   (dclk),
        .clr    (clr),
        .btnr   (btnr),
        .btng   (btng),
        .btnb   (btnb),
        .sw     (sw),
        .red_R  (red_R),
        .green_R(green_R),
        .blue_R (blue_R),
        .upd    (upd)
    );

    always #5 dclk = ~dclk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge dclk);
        #1;
    endtask

    task automatic push(input int unsigned c, input logic [2:0] r, input logic [2:0] g,
                        input logic [1:0] b);
        exp_t e;
        e.cyc = c;
        e.col = {r, g, b};
        sb_q.push_back(e);
    endtask

    // Cycle counter: value after the Nth rising edge is N.
    initial forever begin
        @(posedge dclk);
        cyc++;
    end

    // Monitor: every upd must match the next scoreboard entry; colour must track the model.
    initial forever begin
        exp_t e;
        @(negedge dclk);
        if (clr) begin
            mdl_col = 8'hE0;
        end else if (mon_en) begin
            if (upd) begin
                if (sb_q.size() == 0) begin
                    check_eq("upd_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check_eq("upd_cycle", cyc, e.cyc);
                    mdl_col = e.col;
                end
            end
            check_eq("color", {red_R, green_R, blue_R}, mdl_col);
        end
    end

    initial begin
        clr  = 1'b1;
        btnr = 1'b0;
        btng = 1'b0;
        btnb = 1'b0;
        sw   = 8'h00;
        #1;
        check_eq("rst_red", red_R, 3'd7);
        check_eq("rst_green", green_R, 3'd0);
        check_eq("rst_blue", blue_R, 2'd0);
        check_eq("rst_upd", upd, 1'b0);
        wait_cyc(2);
        clr    = 1'b0;
        mon_en = 1'b1;
        wait_cyc(100);
        check_eq("idle_red", red_R, 3'd7);

        // Clean green press.
        sw = 8'b10_011_101;
        push(cyc + Lat, 3'd7, 3'd3, 2'd0);
        btng = 1'b1;
        wait_cyc(20);
        check_eq("press_green", green_R, 3'd3);
        btng = 1'b0;
        wait_cyc(D + 6);

        // Bouncing red button: 3-cycle pulses never pass the debouncer.
        for (int k = 0; k < 4; k++) begin
            btnr = 1'b1;
            wait_cyc(3);
            btnr = 1'b0;
            wait_cyc(3);
        end
        wait_cyc(10);
        check_eq("bounce_red", red_R, 3'd7);
        push(cyc + Lat, 3'd5, 3'd3, 2'd0);
        btnr = 1'b1;
        wait_cyc(20);
        check_eq("held_red", red_R, 3'd5);
        btnr = 1'b0;
        wait_cyc(D + 6);

        // Simultaneous red and blue press.
        sw = 8'hC2;
        push(cyc + Lat, 3'd2, 3'd3, 2'd3);
        btnr = 1'b1;
        btnb = 1'b1;
        wait_cyc(20);
        btnr = 1'b0;
        btnb = 1'b0;
        wait_cyc(D + 6);

        // Reset mid-debounce discards the partial count.
        btnb = 1'b1;
        wait_cyc(3);
        #2;
        clr = 1'b1;
        #1;
        check_eq("async_rst_red", red_R, 3'd7);
        check_eq("async_rst_green", green_R, 3'd0);
        check_eq("async_rst_blue", blue_R, 2'd0);
        check_eq("async_rst_upd", upd, 1'b0);
        @(posedge dclk);
        #1;
        clr = 1'b0;
        push(cyc + Lat, 3'd7, 3'd0, 2'd3);
        wait_cyc(20);
        btnb = 1'b0;
        wait_cyc(D + 6);

`ifdef COLOR_SEL_AUTOREPEAT_EN
        // Held blue button auto-repeats with wrap.
        sw = 8'h80;
        push(cyc + Lat, 3'd7, 3'd0, 2'd2);
        push(cyc + Lat + R, 3'd7, 3'd0, 2'd3);
        push(cyc + Lat + 2 * R, 3'd7, 3'd0, 2'd0);
        push(cyc + Lat + 3 * R, 3'd7, 3'd0, 2'd1);
        btnb = 1'b1;
        wait_cyc(Lat + 3 * R + 1);
        btnb = 1'b0;
        wait_cyc(30);
`else
        // Long hold gives exactly one load.
        sw = 8'h40;
        push(cyc + Lat, 3'd7, 3'd0, 2'd1);
        btnb = 1'b1;
        wait_cyc(60);
        btnb = 1'b0;
        wait_cyc(D + 6);
`endif

        check_eq("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
